// File: rtl/mips16_pkg.sv
// mips16_pkg: shared MIPS16 sizing constants and the program loader state encoding.
package mips16_pkg;
   localparam int INSTR_W    = 16;
   localparam int IMEM_DEPTH = 16;
   localparam int IMEM_AW    = 4;
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] HI   = 3'd2;
   localparam logic [2:0] LO   = 3'd3;
   localparam logic [2:0] WR   = 3'd4;
   localparam logic [2:0] CHK  = 3'd5;
   localparam logic [2:0] RUN  = 3'd6;
   localparam logic [2:0] ERR  = 3'd7;
endpackage

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams a checksummed program into imem, then releases core_hold.
module imem_prog_loader
   import mips16_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_AW,
   parameter int DATA_W = INSTR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_err
);
   localparam logic [8:0] DEPTH_B = 9'(DEPTH);
   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        csum_q, csum_d;
   logic              rdy_q, rdy_d, take;
   assign take       = byte_valid & rdy_q & ~load_req;
   assign byte_ready = rdy_q;
   assign imem_we    = (state_q == WR) & ~load_req;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign core_hold  = state_q != RUN;
   assign load_done  = state_q == RUN;
   assign load_err   = state_q == ERR;
   assign rdy_d      = state_d inside {HDR, HI, LO, CHK};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      csum_d  = csum_q;
      if (load_req) begin
         state_d = HDR;
         csum_d  = '0;
         waddr_d = '0;
      end else begin
         case (state_q)
            HDR: if (take) begin
               if (byte_in == 8'd0 || {1'b0, byte_in} > DEPTH_B) begin
                  state_d = ERR;
               end else begin
                  cnt_d   = byte_in[ADDR_W:0];
                  waddr_d = '0;
                  csum_d  = byte_in;
                  state_d = HI;
               end
            end
            HI: if (take) begin
               wdata_d = {byte_in, wdata_q[7:0]};
               csum_d  = csum_q ^ byte_in;
               state_d = LO;
            end
            LO: if (take) begin
               wdata_d = {wdata_q[DATA_W-1:8], byte_in};
               csum_d  = csum_q ^ byte_in;
               state_d = WR;
            end
            WR: begin
               // waddr wraps to 0 only after the last write of a full-depth load
               waddr_d = waddr_q + ADDR_W'(1);
               cnt_d   = cnt_q - (ADDR_W+1)'(1);
               state_d = (cnt_q == (ADDR_W+1)'(1)) ? CHK : HI;
            end
            CHK: if (take) state_d = (byte_in == csum_q) ? RUN : ERR;
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         csum_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         csum_q  <= csum_d;
         rdy_q   <= rdy_d;
      end
   end
endmodule

// File: tb/tb_imem_prog_loader.sv
// tb_imem_prog_loader: randomized byte streams checked against a stream-level model of the loader.
module tb_imem_prog_loader;
   logic        clk = 1'b0, rst = 1'b1, load_req = 1'b0, byte_valid = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_ready, imem_we, core_hold, load_done, load_err;
   logic [3:0]  imem_waddr;
   logic [15:0] imem_wdata;
   int          n_chk = 0, n_pass = 0;
   logic [19:0] wq[$];
   logic        prev_we = 1'b0;
   logic [15:0] words[16];
   always #5 clk = ~clk;
   imem_prog_loader dut (
      .clk(clk), .rst(rst), .load_req(load_req), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
   endtask
   // write log sampled mid-cycle, after inputs driven on the falling edge have settled
   always begin
      @(negedge clk);
      #3;
      if (imem_we) begin
         check("we_pulse", 32'(prev_we), 0);
         wq.push_back({imem_waddr, imem_wdata});
      end
      prev_we = imem_we;
   end
   function automatic logic [7:0] xsum(input int n);
      logic [7:0] x = 8'(n);
      for (int i = 0; i < n; i++) x ^= words[i][15:8] ^ words[i][7:0];
      return x;
   endfunction
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_in = b;
      byte_valid = 1'b1;
      while (!byte_ready && t < 64) begin
         @(negedge clk);
         t++;
      end
      check("accept", 32'(byte_ready), 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask
   task automatic pulse_req();
      load_req = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(negedge clk);
      load_req = 1'b0;
      byte_valid = 1'b0;
   endtask
   function automatic int gap_of(input int gmode);
      return gmode == 0 ? 0 : gmode == 1 ? 1 : int'($urandom_range(3, 0));
   endfunction
   task automatic load_stream(input bit req, input int n, input logic [7:0] c, input int gmode);
      if (req) pulse_req();
      send_byte(8'(n), gap_of(gmode));
      if (n >= 1 && n <= 16) begin
         for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], gap_of(gmode));
            send_byte(words[i][7:0], gap_of(gmode));
         end
         send_byte(c, gap_of(gmode));
      end
      repeat (3) @(negedge clk);
   endtask
   task automatic check_result(input int n, input logic [7:0] c);
      bit vld = n >= 1 && n <= 16;
      bit ok  = 1'b0;
      int nw  = vld ? n : 0;
      if (vld) ok = c == xsum(n);
      check("load_done", 32'(load_done), 32'(ok));
      check("load_err", 32'(load_err), 32'(!ok));
      check("core_hold", 32'(core_hold), 32'(!ok));
      check("idle_rdy", 32'(byte_ready), 0);
      check("n_writes", 32'(wq.size()), 32'(nw));
      for (int i = 0; i < nw && i < wq.size(); i++) begin
         check("waddr", 32'(wq[i][19:16]), 32'(i));
         check("wdata", 32'(wq[i][15:0]), 32'(words[i]));
      end
      if (vld) check("waddr_end", 32'(imem_waddr), 32'(n % 16));
   endtask
   initial begin
      int n;
      logic [7:0] c;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_hold", 32'(core_hold), 1);
      check("rst_rdy", 32'(byte_ready), 0);
      check("rst_done", 32'(load_done), 0);
      check("rst_err", 32'(load_err), 0);
      check("rst_waddr", 32'(imem_waddr), 0);
      check("rst_wdata", 32'(imem_wdata), 0);
      check("rst_nwr", 32'(wq.size()), 0);
      words[0] = 16'h0123;
      words[1] = 16'h2345;
      wq.delete();
      load_stream(1'b1, 2, 8'h46, 0);
      check_result(2, 8'h46);
      wq.delete();
      load_stream(1'b1, 2, 8'h47, 2);
      check_result(2, 8'h47);
      wq.delete();
      load_stream(1'b1, 0, 8'h00, 0);
      check_result(0, 8'h00);
      wq.delete();
      load_stream(1'b1, 17, 8'h00, 0);
      check_result(17, 8'h00);
      for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
      wq.delete();
      load_stream(1'b1, 16, xsum(16), 1);
      check_result(16, xsum(16));
      // abort mid-word: load_req while word 1 sits half-received
      words[0] = 16'($urandom);
      words[1] = 16'($urandom);
      wq.delete();
      pulse_req();
      send_byte(8'd2, 0);
      send_byte(words[0][15:8], 0);
      send_byte(words[0][7:0], 0);
      send_byte(words[1][15:8], 0);
      pulse_req();
      repeat (2) @(negedge clk);
      check("abort_rdy", 32'(byte_ready), 1);
      check("abort_hold", 32'(core_hold), 1);
      check("abort_done", 32'(load_done), 0);
      check("abort_nwr", 32'(wq.size()), 1);
      if (wq.size() > 0) check("abort_w0", 32'(wq[0]), {12'h0, 4'd0, words[0]});
      wq.delete();
      words[0] = 16'hABCD;
      load_stream(1'b0, 1, 8'h67, 0);
      check_result(1, 8'h67);
      for (int s = 0; s < 14; s++) begin
         n = $urandom_range(3, 0) == 0 ? int'($urandom_range(18, 0)) : int'($urandom_range(16, 1));
         for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
         c = (n >= 1 && n <= 16) ? xsum(n) : 8'($urandom);
         if ($urandom_range(3, 0) == 0) c ^= 8'(1 << $urandom_range(7, 0));
         wq.delete();
         load_stream(1'b1, n, c, 2);
         check_result(n, c);
      end
      // asynchronous reset while the low byte of word 0 is awaited
      words[0] = 16'($urandom);
      wq.delete();
      pulse_req();
      send_byte(8'd1, 0);
      send_byte(words[0][15:8], 0);
      #2 rst = 1'b1;
      #1;
      check("arst_rdy", 32'(byte_ready), 0);
      check("arst_hold", 32'(core_hold), 1);
      check("arst_we", 32'(imem_we), 0);
      check("arst_done", 32'(load_done), 0);
      check("arst_err", 32'(load_err), 0);
      check("arst_waddr", 32'(imem_waddr), 0);
      check("arst_wdata", 32'(imem_wdata), 0);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in = words[0][7:0];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      byte_valid = 1'b0;
      check("arst_nwr", 32'(wq.size()), 0);
      check("arst_hold2", 32'(core_hold), 1);
      check("arst_rdy2", 32'(byte_ready), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
